// File: rtl/oam_dma.sv
// Sprite DMA: copies COUNT bytes from page {page,8'h00} to the OAM data port while holding the bus.
// Optional odd-cycle alignment stall is enabled with OAM_DMA_ALIGN_EN.
module oam_dma #(
  parameter int            AW       = 16,
  parameter int            DW       = 8,
  parameter logic [AW-1:0] OAM_PORT = 16'h2004,
  parameter int            COUNT    = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trig,
  input  logic [7:0]    page,
  output logic          req,
  input  logic          sel,
  input  logic          ifrdy,
  output logic [AW-1:0] addr,
  output logic          we,
  output logic          en,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          busy,
  output logic          done
);
  localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    READ,
    WRITE,
`ifdef OAM_DMA_ALIGN_EN
    ALIGN,
`endif
    DONE
  } state_t;

  state_t        state, nxt;
  logic [7:0]    src;
  logic [IW-1:0] idx;
  logic [7:0]    lo;
  logic          xfer;

  assign xfer = sel && ifrdy;
  assign lo   = 8'(idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      src      <= '0;
      idx      <= '0;
      data_out <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE:    if (trig) begin src <= page; idx <= '0; end
        READ:    if (xfer) data_out <= data_in;
        WRITE:   if (xfer) idx <= idx + IW'(1);
        default: ;
      endcase
    end
  end

`ifdef OAM_DMA_ALIGN_EN
  logic parity, align;

  // parity runs free; a trigger landing on an odd cycle costs one extra bus cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity <= 1'b0;
      align  <= 1'b0;
    end else begin
      parity <= ~parity;
      if (state == IDLE && trig) align <= parity;
    end
  end
`endif

  always_comb begin
    nxt  = state;
    req  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    en   = 1'b0;
    we   = 1'b0;
    addr = '0;
    case (state)
      IDLE: if (trig) nxt = REQ;
      REQ: begin
        req  = 1'b1;
        busy = 1'b1;
`ifdef OAM_DMA_ALIGN_EN
        if (sel) nxt = align ? ALIGN : READ;
`else
        if (sel) nxt = READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      ALIGN: begin
        req  = 1'b1;
        busy = 1'b1;
        nxt  = READ;
      end
`endif
      READ: begin
        req  = 1'b1;
        busy = 1'b1;
        en   = sel;
        addr = AW'({src, lo});
        if (xfer) nxt = WRITE;
      end
      WRITE: begin
        req  = 1'b1;
        busy = 1'b1;
        en   = sel;
        we   = 1'b1;
        addr = OAM_PORT;
        if (xfer) nxt = (idx == IW'(COUNT - 1)) ? DONE : READ;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: per-cycle sel/ifrdy/trig scripts, transfer-level timing model and byte scoreboard.
module tb_oam_dma;
  localparam logic [15:0] OAM = 16'h2004;
  localparam int NB = 256;
  localparam int MAXK = 4096;
`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic        clk = 0, reset, trig, sel, ifrdy, req, we, en, busy, done;
  logic [7:0]  page, data_in, data_out;
  logic [15:0] addr;
  logic [7:0]  mem [0:65535];
  int          cyc;

  int nchk = 0, nerr = 0;

  bit          sel_a [MAXK], rdy_a [MAXK], trig_a [MAXK];
  logic        ob_en [MAXK];
  logic [15:0] ob_addr [MAXK];
  logic [7:0]  wq [$];
  int          ob_done_cnt, ob_done_k, ob_busy, ob_req_err, ob_waddr_err, first_rk;
  logic [15:0] first_raddr;

  oam_dma dut (
    .clk(clk), .reset(reset), .trig(trig), .page(page), .req(req), .sel(sel),
    .ifrdy(ifrdy), .addr(addr), .we(we), .en(en), .data_in(data_in),
    .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign data_in = mem[addr];

  // cycles since reset; bit 0 is the parity the align option keys on
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0; else cyc <= cyc + 1;

  task automatic script_default();
    for (int k = 0; k < MAXK; k++) begin sel_a[k] = 1; rdy_a[k] = 1; trig_a[k] = 0; end
    trig_a[0] = 1;
  endtask

  task automatic fill_page(input logic [7:0] pg, input bit pattern);
    for (int i = 0; i < NB; i++)
      mem[{pg, 8'(i)}] = pattern ? (8'(i) ^ 8'hA5) : 8'($urandom);
  endtask

  task automatic sync_parity(input int p);
    if (p >= 0 && cyc[0] != p[0]) begin @(posedge clk); #1; end
  endtask

  // transfer-level timing: one grant, optional align cycle, then 2*NB completed accesses
  function automatic int model_done(input bit odd);
    int k, cnt;
    k = 1;
    while (!sel_a[k] && k < MAXK - 2) k++;
    if (ALN && odd) k++;
    cnt = 0;
    while (cnt < 2 * NB && k < MAXK - 2) begin
      k++;
      if (sel_a[k] && rdy_a[k]) cnt++;
    end
    return k + 1;
  endfunction

  function automatic int data_errs(input logic [7:0] pg);
    int e = 0;
    for (int i = 0; i < NB && i < wq.size(); i++)
      if (wq[i] !== mem[{pg, 8'(i)}]) e++;
    return e;
  endfunction

  task automatic run(input logic [7:0] pg, input int exp_done);
    wq.delete();
    ob_done_cnt = 0; ob_done_k = -1; ob_busy = 0; ob_req_err = 0; ob_waddr_err = 0;
    first_rk = -1; first_raddr = 'x;
    for (int k = 0; k <= exp_done + 8 && k < MAXK; k++) begin
      trig = trig_a[k]; sel = sel_a[k]; ifrdy = rdy_a[k];
      page = (k == 0) ? pg : 8'($urandom);
      @(negedge clk);
      ob_en[k] = en; ob_addr[k] = addr;
      if (done) begin ob_done_cnt++; ob_done_k = k; end
      if (busy) ob_busy++;
      if (req !== (k >= 1 && k < exp_done)) ob_req_err++;
      if (en && we && ifrdy) begin
        wq.push_back(data_out);
        if (addr !== OAM) ob_waddr_err++;
      end
      if (en && !we && first_rk < 0) begin first_rk = k; first_raddr = addr; end
      @(posedge clk); #1;
    end
    trig = 0;
  endtask

  task automatic test_reset();
    logic [7:0] pg;
    int bad;
    nchk++;
    if ({req, en, we, addr, data_out, busy, done} !== '0) begin
      nerr++; $display("FAIL reset_init: outputs=%h required 0", {req, en, we, addr, data_out, busy, done});
    end
    pg = 8'($urandom_range(16, 255));
    fill_page(pg, 0);
    trig = 1; page = pg; sel = 1; ifrdy = 1;
    @(posedge clk); #1; trig = 0;
    repeat (41) @(posedge clk);
    #3 reset = 1;
    #1;
    nchk++;
    if ({req, en, we, addr, data_out, busy, done} !== '0) begin
      nerr++; $display("FAIL reset_async: outputs=%h required 0", {req, en, we, addr, data_out, busy, done});
    end
    @(posedge clk); #1 reset = 0;
    bad = 0;
    repeat (6) begin @(negedge clk); if (busy !== 0 || req !== 0 || en !== 0) bad++; end
    @(posedge clk); #1;
    nchk++;
    if (bad != 0) begin nerr++; $display("FAIL reset_idle: active cycles=%0d required 0", bad); end
  endtask

  task automatic test_basic();
    int ed;
    script_default();
    fill_page(8'h02, 1);
    ed = model_done(cyc[0]);
    run(8'h02, ed);
    nchk++; if (ob_done_k !== 514 + ((ALN && ed == 515) ? 1 : 0)) begin nerr++; $display("FAIL basic_done_time: got=%0d required=%0d", ob_done_k, ed); end
    nchk++; if (ob_done_k !== ed) begin nerr++; $display("FAIL basic_done_model: got=%0d required=%0d", ob_done_k, ed); end
    nchk++; if (ob_busy !== ed) begin nerr++; $display("FAIL basic_busy: got=%0d required=%0d", ob_busy, ed); end
    nchk++; if (ob_done_cnt !== 1) begin nerr++; $display("FAIL basic_done_cnt: got=%0d required=1", ob_done_cnt); end
    nchk++; if (wq.size() !== NB) begin nerr++; $display("FAIL basic_wcount: got=%0d required=%0d", wq.size(), NB); end
    nchk++; if (data_errs(8'h02) !== 0) begin nerr++; $display("FAIL basic_data: bad bytes=%0d required 0", data_errs(8'h02)); end
    nchk++; if (ob_waddr_err !== 0) begin nerr++; $display("FAIL basic_waddr: bad=%0d required 0", ob_waddr_err); end
    nchk++; if (ob_req_err !== 0) begin nerr++; $display("FAIL basic_req: bad cycles=%0d required 0", ob_req_err); end
    nchk++; if (first_raddr !== 16'h0200) begin nerr++; $display("FAIL basic_first_addr: got=%h required=0200", first_raddr); end
  endtask

  task automatic test_sel_wait();
    int ed;
    script_default();
    for (int k = 1; k <= 10; k++) sel_a[k] = 0;
    fill_page(8'h02, 1);
    sync_parity(0);
    ed = model_done(1'b0);
    run(8'h02, ed);
    nchk++; if (ob_done_k !== 524) begin nerr++; $display("FAIL selwait_done: got=%0d required=524", ob_done_k); end
    nchk++; if (ob_req_err !== 0) begin nerr++; $display("FAIL selwait_req: bad cycles=%0d required 0", ob_req_err); end
    nchk++; if (first_rk !== 12 || first_raddr !== 16'h0200) begin
      nerr++; $display("FAIL selwait_first_read: cycle=%0d addr=%h required 12/0200", first_rk, first_raddr);
    end
    nchk++; if (data_errs(8'h02) !== 0 || wq.size() !== NB) begin nerr++; $display("FAIL selwait_data: n=%0d bad=%0d", wq.size(), data_errs(8'h02)); end
  endtask

  task automatic test_ifrdy_stall();
    int ed;
    script_default();
    rdy_a[12] = 0; rdy_a[13] = 0;
    fill_page(8'h02, 1);
    sync_parity(0);
    ed = model_done(1'b0);
    run(8'h02, ed);
    nchk++; if (ob_done_k !== 516) begin nerr++; $display("FAIL stall_done: got=%0d required=516", ob_done_k); end
    for (int k = 12; k <= 14; k++) begin
      nchk++;
      if (ob_en[k] !== 1 || ob_addr[k] !== 16'h0205) begin
        nerr++; $display("FAIL stall_hold k=%0d: en=%b addr=%h required 1/0205", k, ob_en[k], ob_addr[k]);
      end
    end
    nchk++; if (data_errs(8'h02) !== 0 || wq.size() !== NB) begin nerr++; $display("FAIL stall_data: n=%0d bad=%0d", wq.size(), data_errs(8'h02)); end
  endtask

  task automatic test_retrig();
    int ed;
    logic [7:0] pg;
    script_default();
    trig_a[202] = 1;
    pg = 8'($urandom);
    fill_page(pg, 0);
    sync_parity(0);
    ed = model_done(1'b0);
    run(pg, ed);
    nchk++; if (ob_done_cnt !== 1 || ob_done_k !== 514) begin nerr++; $display("FAIL retrig_done: cnt=%0d at=%0d required 1/514", ob_done_cnt, ob_done_k); end
    nchk++; if (wq.size() !== NB || data_errs(pg) !== 0) begin nerr++; $display("FAIL retrig_data: n=%0d bad=%0d", wq.size(), data_errs(pg)); end
  endtask

  task automatic test_random();
    int ed;
    logic [7:0] pg;
    bit odd;
    for (int it = 0; it < 3; it++) begin
      script_default();
      for (int k = 1; k < MAXK; k++) begin
        sel_a[k] = ($urandom_range(0, 4) != 0);
        rdy_a[k] = ($urandom_range(0, 3) != 0);
      end
      pg = 8'($urandom);
      fill_page(pg, 0);
      odd = cyc[0];
      ed = model_done(odd);
      run(pg, ed);
      nchk++; if (ob_done_k !== ed || ob_busy !== ed) begin nerr++; $display("FAIL rand%0d_time: done=%0d busy=%0d required %0d", it, ob_done_k, ob_busy, ed); end
      nchk++; if (wq.size() !== NB || data_errs(pg) !== 0 || ob_waddr_err !== 0) begin
        nerr++; $display("FAIL rand%0d_data: n=%0d bad=%0d waddr=%0d", it, wq.size(), data_errs(pg), ob_waddr_err);
      end
      nchk++; if (ob_req_err !== 0 || ob_done_cnt !== 1) begin nerr++; $display("FAIL rand%0d_req: bad=%0d dones=%0d", it, ob_req_err, ob_done_cnt); end
    end
  endtask

  task automatic test_align();
    int ed;
    for (int p = 0; p < 2; p++) begin
      script_default();
      fill_page(8'h03, 0);
      sync_parity(p);
      ed = model_done(p[0]);
      run(8'h03, ed);
      nchk++;
      if (ob_busy !== ((ALN && p == 1) ? 515 : 514)) begin
        nerr++; $display("FAIL align_busy par=%0d: got=%0d required=%0d", p, ob_busy, (ALN && p == 1) ? 515 : 514);
      end
      nchk++; if (wq.size() !== NB || data_errs(8'h03) !== 0) begin nerr++; $display("FAIL align_data par=%0d: n=%0d bad=%0d", p, wq.size(), data_errs(8'h03)); end
    end
  endtask

  initial begin
    reset = 1; trig = 0; sel = 0; ifrdy = 0; page = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    test_reset();
    test_basic();
    test_sel_wait();
    test_ifrdy_stall();
    test_retrig();
    test_random();
    test_align();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
